// File: rtl/accum_pkg.sv
// accum_pkg: shared operation and FSM state encodings for the accumulator unit
package accum_pkg;
    typedef enum logic [1:0] {MODE_ADD, MODE_SUB, MODE_LOAD, MODE_CLEAR} mode_e;
    typedef enum logic {S_IDLE, S_HELD} state_e;
endpackage

// File: rtl/accum_unit_if.sv
// accum_unit_if: button/switch inputs and display-side outputs of the accumulator
interface accum_unit_if #(
    parameter int WIDTH = 16,
    parameter int OP_W  = 10,
    parameter int DEPTH = 4
) ();
    import accum_pkg::*;
    localparam int HW = $clog2(DEPTH + 1);
    logic             Run_Accumulate;
    logic             Undo_n;
    mode_e            Mode;
    logic [OP_W-1:0]  Operand;
    logic [WIDTH-1:0] Acc;
    logic             Carry;
    logic             Ovf;
    logic [HW-1:0]    Hist_Count;
    logic             Busy;
    modport master (
        output Run_Accumulate, Undo_n, Mode, Operand,
        input  Acc, Carry, Ovf, Hist_Count, Busy
    );
    modport slave (
        input  Run_Accumulate, Undo_n, Mode, Operand,
        output Acc, Carry, Ovf, Hist_Count, Busy
    );
endinterface

// File: rtl/btn_sync.sv
// btn_sync: two-flop synchroniser for an active-low button, idling released
module btn_sync (
    input  logic Clk,
    input  logic Reset_Clear,
    input  logic btn,
    output logic sync
);
    logic meta;
    // shift the raw button through two flops; reset to released
    always_ff @(posedge Clk or negedge Reset_Clear) begin
        if (!Reset_Clear) {sync, meta} <= 2'b11;
        else              {sync, meta} <= {meta, btn};
    end
endmodule

// File: rtl/accum_unit.sv
// accum_unit: one add/sub/load/clear per button press with carry, sticky overflow and undo history
module accum_unit
    import accum_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int OP_W  = 10,
    parameter int DEPTH = 4
) (
    input logic        Clk,
    input logic        Reset_Clear,
    accum_unit_if.slave bus
);
    localparam int HW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic             run_s, undo_s;
    state_e           state, state_nx;
    logic             do_op, do_undo;
    logic [WIDTH-1:0] acc, ext;
    logic [WIDTH:0]   res;
    logic             carry, ovf;
    logic [HW-1:0]    cnt;
    logic [PW-1:0]    wptr, wp_inc, wp_dec;
    logic [WIDTH-1:0] mem [DEPTH];

    btn_sync u_run  (.Clk, .Reset_Clear, .btn(bus.Run_Accumulate), .sync(run_s));
    btn_sync u_undo (.Clk, .Reset_Clear, .btn(bus.Undo_n),         .sync(undo_s));

    // FSM state register
    always_ff @(posedge Clk or negedge Reset_Clear) begin
        if (!Reset_Clear) state <= S_IDLE;
        else              state <= state_nx;
    end

    // one action on leaving IDLE; run beats undo; wait in HELD until both buttons are up
    always_comb begin
        state_nx = (run_s && undo_s) ? S_IDLE : S_HELD;
        do_op    = (state == S_IDLE) && !run_s;
        do_undo  = (state == S_IDLE) && run_s && !undo_s;
    end

    assign ext    = WIDTH'(bus.Operand);
    assign wp_inc = (wptr == PW'(DEPTH - 1)) ? '0 : wptr + 1'b1;
    assign wp_dec = (wptr == '0) ? PW'(DEPTH - 1) : wptr - 1'b1;

    // result with carry/borrow in the top bit; LOAD and CLEAR leave it zero
    always_comb begin
        res = (bus.Mode == MODE_ADD)  ? {1'b0, acc} + {1'b0, ext} :
              (bus.Mode == MODE_SUB)  ? {1'b0, acc} - {1'b0, ext} :
              (bus.Mode == MODE_LOAD) ? {1'b0, ext} : '0;
    end

    // accumulator, flags and history pointer/count
    always_ff @(posedge Clk or negedge Reset_Clear) begin
        if (!Reset_Clear) begin
            acc   <= '0;
            carry <= 1'b0;
            ovf   <= 1'b0;
            cnt   <= '0;
            wptr  <= '0;
        end else if (do_op) begin
            acc   <= res[WIDTH-1:0];
            carry <= res[WIDTH];
            ovf   <= (bus.Mode != MODE_CLEAR) && (ovf || res[WIDTH]);
            cnt   <= (cnt == HW'(DEPTH)) ? cnt : cnt + 1'b1;
            wptr  <= wp_inc;
        end else if (do_undo && cnt != '0) begin
            acc   <= mem[wp_dec];
            carry <= 1'b0;
            cnt   <= cnt - 1'b1;
            wptr  <= wp_dec;
        end
    end

    // history storage: push pre-op value, overwriting the oldest once full
    always_ff @(posedge Clk) begin
        if (do_op) mem[wptr] <= acc;
    end

    assign bus.Acc        = acc;
    assign bus.Carry      = carry;
    assign bus.Ovf        = ovf;
    assign bus.Hist_Count = cnt;
    assign bus.Busy       = (state == S_HELD);
endmodule

// File: tb/tb_accum_unit.sv
// tb_accum_unit: directed vector table plus hand-written timing sequences for accum_unit
module tb_accum_unit;
    import accum_pkg::*;

    typedef struct {
        logic        undo;
        mode_e       mode;
        logic [9:0]  opnd;
        logic [15:0] acc;
        logic        c;
        logic        o;
        logic [2:0]  h;
    } vec_t;

    logic Clk = 1'b0;
    logic Reset_Clear = 1'b0;
    int   checks = 0;
    int   failures = 0;
    vec_t tbl [21];

    accum_unit_if #(.WIDTH(16), .OP_W(10), .DEPTH(4)) bus ();
    accum_unit #(.WIDTH(16), .OP_W(10), .DEPTH(4)) dut (
        .Clk(Clk), .Reset_Clear(Reset_Clear), .bus(bus.slave)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic press(input logic u, input mode_e m, input logic [9:0] d);
        @(negedge Clk);
        bus.Mode = m;
        bus.Operand = d;
        if (u) bus.Undo_n = 1'b0;
        else   bus.Run_Accumulate = 1'b0;
        repeat (4) @(negedge Clk);
        bus.Undo_n = 1'b1;
        bus.Run_Accumulate = 1'b1;
        repeat (4) @(negedge Clk);
    endtask

    initial begin
        tbl[0]  = '{1'b0, MODE_LOAD,  10'h3ff, 16'h03ff, 1'b0, 1'b0, 3'd1};
        tbl[1]  = '{1'b0, MODE_ADD,   10'h001, 16'h0400, 1'b0, 1'b0, 3'd2};
        tbl[2]  = '{1'b0, MODE_LOAD,  10'h005, 16'h0005, 1'b0, 1'b0, 3'd3};
        tbl[3]  = '{1'b0, MODE_SUB,   10'h007, 16'hfffe, 1'b1, 1'b1, 3'd4};
        tbl[4]  = '{1'b0, MODE_LOAD,  10'h010, 16'h0010, 1'b0, 1'b1, 3'd4};
        tbl[5]  = '{1'b0, MODE_CLEAR, 10'h3ff, 16'h0000, 1'b0, 1'b0, 3'd4};
        tbl[6]  = '{1'b1, MODE_ADD,   10'h000, 16'h0010, 1'b0, 1'b0, 3'd3};
        tbl[7]  = '{1'b1, MODE_ADD,   10'h000, 16'hfffe, 1'b0, 1'b0, 3'd2};
        tbl[8]  = '{1'b1, MODE_ADD,   10'h000, 16'h0005, 1'b0, 1'b0, 3'd1};
        tbl[9]  = '{1'b1, MODE_ADD,   10'h000, 16'h0400, 1'b0, 1'b0, 3'd0};
        tbl[10] = '{1'b1, MODE_ADD,   10'h000, 16'h0400, 1'b0, 1'b0, 3'd0};
        tbl[11] = '{1'b0, MODE_LOAD,  10'h001, 16'h0001, 1'b0, 1'b0, 3'd1};
        tbl[12] = '{1'b0, MODE_ADD,   10'h001, 16'h0002, 1'b0, 1'b0, 3'd2};
        tbl[13] = '{1'b0, MODE_ADD,   10'h001, 16'h0003, 1'b0, 1'b0, 3'd3};
        tbl[14] = '{1'b0, MODE_ADD,   10'h001, 16'h0004, 1'b0, 1'b0, 3'd4};
        tbl[15] = '{1'b0, MODE_ADD,   10'h001, 16'h0005, 1'b0, 1'b0, 3'd4};
        tbl[16] = '{1'b1, MODE_ADD,   10'h000, 16'h0004, 1'b0, 1'b0, 3'd3};
        tbl[17] = '{1'b1, MODE_ADD,   10'h000, 16'h0003, 1'b0, 1'b0, 3'd2};
        tbl[18] = '{1'b1, MODE_ADD,   10'h000, 16'h0002, 1'b0, 1'b0, 3'd1};
        tbl[19] = '{1'b1, MODE_ADD,   10'h000, 16'h0001, 1'b0, 1'b0, 3'd0};
        tbl[20] = '{1'b1, MODE_ADD,   10'h000, 16'h0001, 1'b0, 1'b0, 3'd0};

        bus.Run_Accumulate = 1'b1;
        bus.Undo_n = 1'b1;
        bus.Mode = MODE_ADD;
        bus.Operand = '0;
        repeat (3) @(negedge Clk);
        chk("rst_acc",  32'(bus.Acc), 32'h0);
        chk("rst_carry", 32'(bus.Carry), 32'h0);
        chk("rst_ovf",  32'(bus.Ovf), 32'h0);
        chk("rst_hist", 32'(bus.Hist_Count), 32'h0);
        chk("rst_busy", 32'(bus.Busy), 32'h0);
        Reset_Clear = 1'b1;
        repeat (2) @(negedge Clk);

        for (int i = 0; i < 21; i++) begin
            press(tbl[i].undo, tbl[i].mode, tbl[i].opnd);
            chk($sformatf("v%0d_acc", i),   32'(bus.Acc),        32'(tbl[i].acc));
            chk($sformatf("v%0d_carry", i), 32'(bus.Carry),      32'(tbl[i].c));
            chk($sformatf("v%0d_ovf", i),   32'(bus.Ovf),        32'(tbl[i].o));
            chk($sformatf("v%0d_hist", i),  32'(bus.Hist_Count), 32'(tbl[i].h));
            chk($sformatf("v%0d_busy", i),  32'(bus.Busy),       32'h0);
        end

        press(1'b0, MODE_LOAD, 10'h3ff);
        repeat (63) press(1'b0, MODE_ADD, 10'h3ff);
        chk("wrap_pre_acc",   32'(bus.Acc),   32'hffc0);
        chk("wrap_pre_carry", 32'(bus.Carry), 32'h0);
        chk("wrap_pre_ovf",   32'(bus.Ovf),   32'h0);
        press(1'b0, MODE_ADD, 10'h3ff);
        chk("wrap_acc",   32'(bus.Acc),   32'h03bf);
        chk("wrap_carry", 32'(bus.Carry), 32'h1);
        chk("wrap_ovf",   32'(bus.Ovf),   32'h1);
        press(1'b0, MODE_ADD, 10'h001);
        chk("sticky_acc",   32'(bus.Acc),   32'h03c0);
        chk("sticky_carry", 32'(bus.Carry), 32'h0);
        chk("sticky_ovf",   32'(bus.Ovf),   32'h1);
        chk("sticky_hist",  32'(bus.Hist_Count), 32'd4);

        press(1'b0, MODE_CLEAR, 10'h000);
        @(negedge Clk);
        bus.Mode = MODE_ADD;
        bus.Operand = 10'h002;
        bus.Run_Accumulate = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
        chk("hold_k_acc", 32'(bus.Acc), 32'h0);
        @(negedge Clk);
        chk("hold_k1_acc",  32'(bus.Acc),  32'h0);
        chk("hold_k1_busy", 32'(bus.Busy), 32'h0);
        @(negedge Clk);
        chk("hold_k2_acc",  32'(bus.Acc),  32'h2);
        chk("hold_k2_busy", 32'(bus.Busy), 32'h1);
        bus.Operand = 10'h155;
        bus.Mode = MODE_SUB;
        repeat (50) @(negedge Clk);
        chk("hold_once_acc", 32'(bus.Acc),  32'h2);
        chk("hold_busy",     32'(bus.Busy), 32'h1);
        bus.Run_Accumulate = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        chk("rel_r1_busy", 32'(bus.Busy), 32'h1);
        @(negedge Clk);
        chk("rel_r2_busy", 32'(bus.Busy), 32'h0);
        chk("rel_acc",     32'(bus.Acc),  32'h2);

        press(1'b0, MODE_LOAD, 10'h020);
        @(negedge Clk);
        bus.Mode = MODE_ADD;
        bus.Operand = 10'h010;
        bus.Run_Accumulate = 1'b0;
        bus.Undo_n = 1'b0;
        repeat (4) @(negedge Clk);
        chk("both_acc",  32'(bus.Acc),        32'h0030);
        chk("both_hist", 32'(bus.Hist_Count), 32'd4);
        chk("both_busy", 32'(bus.Busy),       32'h1);
        #3;
        Reset_Clear = 1'b0;
        #1;
        chk("mid_rst_acc",  32'(bus.Acc),        32'h0);
        chk("mid_rst_hist", 32'(bus.Hist_Count), 32'h0);
        chk("mid_rst_busy", 32'(bus.Busy),       32'h0);
        chk("mid_rst_ovf",  32'(bus.Ovf),        32'h0);
        repeat (2) @(negedge Clk);
        chk("in_rst_acc", 32'(bus.Acc), 32'h0);
        Reset_Clear = 1'b1;
        @(negedge Clk);
        chk("post_rst_e1_acc", 32'(bus.Acc), 32'h0);
        repeat (2) @(negedge Clk);
        chk("post_rst_acc",  32'(bus.Acc),        32'h0010);
        chk("post_rst_hist", 32'(bus.Hist_Count), 32'd1);
        chk("post_rst_busy", 32'(bus.Busy),       32'h1);
        repeat (5) @(negedge Clk);
        chk("post_rst_once", 32'(bus.Acc), 32'h0010);
        bus.Run_Accumulate = 1'b1;
        bus.Undo_n = 1'b1;
        repeat (4) @(negedge Clk);
        press(1'b1, MODE_ADD, 10'h000);
        chk("final_undo_acc",  32'(bus.Acc),        32'h0);
        chk("final_undo_hist", 32'(bus.Hist_Count), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
